// File: rtl/psx_rcnt_pkg.sv
// psx_rcnt_pkg: MODE layout, address map and helpers for the root counter.
// Toggle IRQ mode is built in only when PSX_RCNT_TOGGLE_EN is defined.
package psx_rcnt_pkg;

    localparam int MB_IRQ_N     = 10;
    localparam int MB_REACH_TGT = 11;
    localparam int MB_REACH_FF  = 12;

    localparam logic [15:0] MODE_RST     = 16'h0400;
    localparam logic [15:0] MODE_WR_MASK = 16'h03FF;

    typedef enum logic [1:0] {
        RC_COUNT  = 2'd0,
        RC_MODE   = 2'd1,
        RC_TARGET = 2'd2
    } rcnt_addr_e;

    typedef struct packed {
        logic [2:0] rsvd;
        logic       reach_ffff;
        logic       reach_tgt;
        logic       irq_n;
        logic [1:0] clk_src;
        logic       toggle;
        logic       rpt;
        logic       irq_ffff;
        logic       irq_tgt;
        logic       rst_tgt;
        logic [1:0] sync_mode;
        logic       sync_en;
    } rcnt_mode_t;

    function automatic logic [15:0] byte_merge(
        input logic [15:0] old_v,
        input logic [15:0] new_v,
        input logic [1:0]  be
    );
        return {be[1] ? new_v[15:8] : old_v[15:8],
                be[0] ? new_v[7:0]  : old_v[7:0]};
    endfunction

endpackage

// File: rtl/psx_rcnt_tick_gen.sv
// psx_rcnt_tick_gen: clock-source select and blank-synchronised gating.
// Produces the per-cycle count enable and the blank-rise clear.
module psx_rcnt_tick_gen
    import psx_rcnt_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       mode_wr,
    input  logic       sync_en,
    input  logic [1:0] sync_mode,
    input  logic [1:0] clk_src,
    input  logic       tick_alt,
    input  logic       blank,
    output logic       cnt_en,
    output logic       cnt_clr
);

    logic blank_q;
    logic armed_q;
    logic src_sel;
    logic src_tick;
    logic blank_rise;

    assign src_sel    = (CHANNEL == 2) ? clk_src[1] : clk_src[0];
    assign src_tick   = src_sel ? tick_alt : 1'b1;
    assign blank_rise = blank & ~blank_q;

    // armed_q remembers the first blank rise for sync mode 3
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            blank_q <= blank;
            armed_q <= mode_wr ? 1'b0 : (armed_q | blank_rise);
        end
    end

    always_comb begin
        cnt_en  = src_tick;
        cnt_clr = 1'b0;
        if (sync_en) begin
            if (CHANNEL == 2) begin
                cnt_en = src_tick & (^sync_mode);
            end else begin
                unique case (sync_mode)
                    2'd0: cnt_en = src_tick & ~blank;
                    2'd1: cnt_clr = blank_rise;
                    2'd2: begin
                        cnt_en  = src_tick & blank;
                        cnt_clr = blank_rise;
                    end
                    default: cnt_en = src_tick & armed_q;
                endcase
            end
        end
    end

endmodule

// File: rtl/psx_root_counter.sv
// psx_root_counter: one PSX root counter channel with COUNT/MODE/TARGET.
// Define PSX_RCNT_TOGGLE_EN to enable the toggle IRQ mode (MODE[7]).
module psx_root_counter
    import psx_rcnt_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        wen,
    input  logic        ren,
    input  logic [1:0]  ben,
    input  logic [1:0]  addr,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    input  logic        tick_alt,
    input  logic        blank,
    output logic        irq_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_FIRED
    } irq_state_e;

    irq_state_e  state_q;
    rcnt_mode_t  mode_q;
    logic [15:0] count_q;
    logic [15:0] target_q;
    logic [15:0] mode_wdata;
    logic        cnt_wr;
    logic        mode_wr;
    logic        tgt_wr;
    logic        flag_clr;
    logic        cnt_en;
    logic        cnt_clr;
    logic        tick;
    logic        hit_tgt;
    logic        hit_ffff;
    logic        event_hit;
    logic        toggle_mode;

    assign cnt_wr   = wen && (addr == RC_COUNT);
    assign mode_wr  = wen && (addr == RC_MODE);
    assign tgt_wr   = wen && (addr == RC_TARGET);
    assign flag_clr = ren && (addr == RC_MODE);

    assign mode_wdata = (byte_merge(mode_q, data_i, ben) & MODE_WR_MASK)
                      | MODE_RST;

`ifdef PSX_RCNT_TOGGLE_EN
    assign toggle_mode = mode_q.toggle;
`else
    assign toggle_mode = 1'b0;
`endif

    psx_rcnt_tick_gen #(
        .CHANNEL (CHANNEL)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .mode_wr   (mode_wr),
        .sync_en   (mode_q.sync_en),
        .sync_mode (mode_q.sync_mode),
        .clk_src   (mode_q.clk_src),
        .tick_alt  (tick_alt),
        .blank     (blank),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr)
    );

    // register writes and the blank clear both override a tick
    assign tick      = cnt_en & ~cnt_wr & ~mode_wr & ~cnt_clr;
    assign hit_tgt   = (count_q == target_q);
    assign hit_ffff  = (count_q == 16'hFFFF);
    assign event_hit = tick && ((hit_tgt && mode_q.irq_tgt)
                             || (hit_ffff && mode_q.irq_ffff));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 16'h0;
            target_q <= 16'h0;
        end else begin
            if (mode_wr) begin
                count_q <= 16'h0;
            end else if (cnt_wr) begin
                count_q <= byte_merge(count_q, data_i, ben);
            end else if (cnt_clr) begin
                count_q <= 16'h0;
            end else if (tick) begin
                count_q <= (hit_tgt && mode_q.rst_tgt) ? 16'h0
                                                       : count_q + 16'h1;
            end
            if (tgt_wr) begin
                target_q <= byte_merge(target_q, data_i, ben);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= rcnt_mode_t'(MODE_RST);
            state_q <= S_IDLE;
        end else if (mode_wr) begin
            mode_q  <= rcnt_mode_t'(mode_wdata);
            state_q <= S_IDLE;
        end else begin
            if (tick && hit_tgt) begin
                mode_q[MB_REACH_TGT] <= 1'b1;
            end else if (flag_clr) begin
                mode_q[MB_REACH_TGT] <= 1'b0;
            end
            if (tick && hit_ffff) begin
                mode_q[MB_REACH_FF] <= 1'b1;
            end else if (flag_clr) begin
                mode_q[MB_REACH_FF] <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (event_hit) begin
                        if (toggle_mode) begin
                            mode_q[MB_IRQ_N] <= ~mode_q.irq_n;
                            if (!mode_q.rpt) state_q <= S_FIRED;
                        end else begin
                            mode_q[MB_IRQ_N] <= 1'b0;
                            state_q <= S_PULSE;
                        end
                    end
                end
                S_PULSE: begin
                    mode_q[MB_IRQ_N] <= 1'b1;
                    state_q <= mode_q.rpt ? S_IDLE : S_FIRED;
                end
                S_FIRED: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign irq_n = mode_q.irq_n;

    always_comb begin
        data_o = 16'h0;
        unique case (1'b1)
            addr == RC_COUNT:  data_o = count_q;
            addr == RC_MODE:   data_o = mode_q;
            addr == RC_TARGET: data_o = target_q;
            default:           data_o = 16'h0;
        endcase
    end

endmodule

// File: tb/tb_psx_root_counter.sv
// tb_psx_root_counter: three channels checked every cycle against a model,
// plus directed vectors for target, one-shot, wrap, sync, toggle and reset.
`timescale 1ns/1ps
module tb_psx_root_counter;

`ifdef PSX_RCNT_TOGGLE_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [1:0]  ben = 2'b11;
    logic [1:0]  addr = 2'd0;
    logic [15:0] data_i = 16'h0;
    logic        tick_alt = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] d0, d1, d2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    psx_root_counter #(.CHANNEL(0)) u0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .wen(wen), .ren(ren), .ben(ben),
        .addr(addr), .data_i(data_i), .data_o(d0), .tick_alt(tick_alt),
        .blank(blank), .irq_n(irq0));
    psx_root_counter #(.CHANNEL(1)) u1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .wen(wen), .ren(ren), .ben(ben),
        .addr(addr), .data_i(data_i), .data_o(d1), .tick_alt(tick_alt),
        .blank(blank), .irq_n(irq1));
    psx_root_counter #(.CHANNEL(2)) u2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .wen(wen), .ren(ren), .ben(ben),
        .addr(addr), .data_i(data_i), .data_o(d2), .tick_alt(tick_alt),
        .blank(blank), .irq_n(irq2));

    // reference state, one entry per channel
    logic [15:0] m_cnt [3];
    logic [15:0] m_tgt [3];
    logic [9:0]  m_mode [3];
    bit m_ft [3];
    bit m_ff [3];
    bit m_irq [3];
    bit m_low [3];
    bit m_spent [3];
    bit m_bprev [3];
    bit m_armed [3];

    function automatic logic [15:0] bmerge(logic [15:0] o, logic [15:0] n,
                                           logic [1:0] b);
        return {b[1] ? n[15:8] : o[15:8], b[0] ? n[7:0] : o[7:0]};
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = 16'h0; m_tgt[c] = 16'h0; m_mode[c] = 10'h0;
            m_ft[c] = 0; m_ff[c] = 0; m_irq[c] = 1; m_low[c] = 0;
            m_spent[c] = 0; m_bprev[c] = 0; m_armed[c] = 0;
        end
    endfunction

    function automatic logic [15:0] model_read(int c, logic [1:0] a);
        case (a)
            2'd0: return m_cnt[c];
            2'd1: return {3'b0, m_ff[c], m_ft[c], m_irq[c], m_mode[c]};
            2'd2: return m_tgt[c];
            default: return 16'h0;
        endcase
    endfunction

    function automatic void model_step();
        for (int c = 0; c < 3; c++) begin
            logic [9:0] md;
            logic [15:0] mw;
            bit src, run, clr, rise, tick, ev, hit_t, hit_f, tog;
            bit mwr, cwr, twr;
            md = m_mode[c];
            mwr = wen && addr == 2'd1;
            cwr = wen && addr == 2'd0;
            twr = wen && addr == 2'd2;
            src = (c == 2 ? md[9] : md[8]) ? tick_alt : 1'b1;
            rise = blank && !m_bprev[c];
            run = src;
            clr = 0;
            if (md[0]) begin
                if (c == 2) run = src && (md[2:1] == 2'd1 || md[2:1] == 2'd2);
                else if (md[2:1] == 2'd0) run = src && !blank;
                else if (md[2:1] == 2'd1) clr = rise;
                else if (md[2:1] == 2'd2) begin run = src && blank; clr = rise; end
                else run = src && m_armed[c];
            end
            tick = run && !clr && !cwr && !mwr;
            hit_t = m_cnt[c] == m_tgt[c];
            hit_f = m_cnt[c] == 16'hFFFF;
            ev = tick && ((hit_t && md[4]) || (hit_f && md[5]));
            tog = TOG_EN && md[7];
            m_bprev[c] = blank;
            if (twr) m_tgt[c] = bmerge(m_tgt[c], data_i, ben);
            if (mwr) begin
                mw = bmerge({6'b0, md}, data_i, ben);
                m_mode[c] = mw[9:0];
                m_cnt[c] = 16'h0; m_ft[c] = 0; m_ff[c] = 0; m_irq[c] = 1;
                m_low[c] = 0; m_spent[c] = 0; m_armed[c] = 0;
            end else begin
                if (rise) m_armed[c] = 1;
                if (tick && hit_t) m_ft[c] = 1;
                else if (ren && addr == 2'd1) m_ft[c] = 0;
                if (tick && hit_f) m_ff[c] = 1;
                else if (ren && addr == 2'd1) m_ff[c] = 0;
                if (cwr) m_cnt[c] = bmerge(m_cnt[c], data_i, ben);
                else if (clr) m_cnt[c] = 16'h0;
                else if (tick) m_cnt[c] = (hit_t && md[3]) ? 16'h0 : m_cnt[c] + 16'd1;
                if (m_low[c]) begin
                    m_irq[c] = 1; m_low[c] = 0;
                    if (!md[6]) m_spent[c] = 1;
                end else if (ev && !m_spent[c]) begin
                    if (tog) begin
                        m_irq[c] = !m_irq[c];
                        if (!md[6]) m_spent[c] = 1;
                    end else begin
                        m_irq[c] = 0; m_low[c] = 1;
                    end
                end
            end
        end
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_ch(int c, logic [15:0] d, logic i);
        chk($sformatf("model_ch%0d_data_a%0d", c, addr), d, model_read(c, addr));
        chk($sformatf("model_ch%0d_irq_n", c), {15'b0, i}, {15'b0, m_irq[c]});
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        model_step();
        chk_ch(0, d0, irq0);
        chk_ch(1, d1, irq1);
        chk_ch(2, d2, irq2);
    endtask

    task automatic wr(logic [1:0] a, logic [15:0] d);
        wen = 1'b1; ren = 1'b0; addr = a; ben = 2'b11; data_i = d;
        step();
        wen = 1'b0;
    endtask

    task automatic reset_checks(string tag);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            chk($sformatf("%s_ch0_a%0d", tag, a), d0, a == 1 ? 16'h0400 : 16'h0);
            chk($sformatf("%s_ch1_a%0d", tag, a), d1, a == 1 ? 16'h0400 : 16'h0);
            chk($sformatf("%s_ch2_a%0d", tag, a), d2, a == 1 ? 16'h0400 : 16'h0);
        end
        chk({tag, "_irq"}, {13'b0, irq0, irq1, irq2}, 16'h0007);
    endtask

    typedef struct {
        logic        ren;
        logic [1:0]  addr;
        logic [15:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [18];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lows;
        int trans;
        logic prev;

        for (int k = 1; k <= 18; k++) begin
            tbl[k-1].addr = (k == 13 || k == 14) ? 2'd1 : 2'd0;
            tbl[k-1].ren = (k == 14);
            tbl[k-1].exp_data = (k == 13) ? 16'h0C58 :
                                (k == 14) ? 16'h0458 : 16'(k % 6);
            tbl[k-1].exp_irq = (k % 6) != 0;
        end

        model_reset();
        #1 rst_n = 1'b0;
        #20;
        reset_checks("reset");
        @(negedge sys_clk);
        rst_n = 1'b1;
        addr = 2'd0;
        repeat (3) step();

        // channel 0: target 5 with reset and repeat, sysclk source
        wr(2'd2, 16'd5);
        wr(2'd1, 16'h0058);
        for (int i = 0; i < 18; i++) begin
            ren = tbl[i].ren;
            addr = tbl[i].addr;
            step();
            chk($sformatf("tbl%0d_data", i), d0, tbl[i].exp_data);
            chk($sformatf("tbl%0d_irq", i), {15'b0, irq0}, {15'b0, tbl[i].exp_irq});
        end
        ren = 1'b0;

        // one-shot: several target hits, a single pulse, then re-arm
        wr(2'd2, 16'd3);
        wr(2'd1, 16'h0018);
        lows = 0;
        repeat (20) begin step(); if (!irq0) lows++; end
        chk("oneshot_pulses", 16'(lows), 16'd1);
        addr = 2'd1;
        #1;
        chk("oneshot_flag", d0, 16'h0C18);
        wr(2'd1, 16'h0018);
        lows = 0;
        repeat (20) begin step(); if (!irq0) lows++; end
        chk("oneshot_rearm", 16'(lows), 16'd1);

        // 0xFFFF wrap; a COUNT write beats a same-cycle tick
        wr(2'd1, 16'h0020);
        wr(2'd0, 16'hFFFE);
        chk("wrap_wr", d0, 16'hFFFE);
        step();
        chk("wrap_ffff", d0, 16'hFFFF);
        step();
        chk("wrap_zero", d0, 16'h0000);
        chk("wrap_irq", {15'b0, irq0}, 16'h0);
        addr = 2'd1;
        #1;
        chk("wrap_mode", d0, 16'h1020);
        addr = 2'd0;
        step();
        chk("wrap_irq_rel", {15'b0, irq0}, 16'h1);
        wr(2'd0, 16'h1234);
        chk("cnt_wr_wins", d0, 16'h1234);

        // channel 1 sync: mode 1 clears on blank rise, mode 0 pauses
        wr(2'd1, 16'h0003);
        addr = 2'd0;
        repeat (3) step();
        chk("sync1_run", d1, 16'd3);
        blank = 1'b1;
        step();
        chk("sync1_clr", d1, 16'd0);
        step();
        chk("sync1_after", d1, 16'd1);
        wr(2'd1, 16'h0001);
        addr = 2'd0;
        repeat (3) step();
        chk("sync0_pause_ch1", d1, 16'd0);
        chk("sync0_pause_ch0", d0, 16'd0);
        blank = 1'b0;
        repeat (2) step();
        chk("sync0_resume", d1, 16'd2);

        // channel 2: alternate source strobe every 8th cycle
        wr(2'd1, 16'h0200);
        addr = 2'd0;
        for (int i = 0; i < 32; i++) begin tick_alt = (i % 8 == 7); step(); end
        tick_alt = 1'b0;
        chk("ch2_alt", d2, 16'd4);
        wr(2'd1, 16'h0201);
        addr = 2'd0;
        for (int i = 0; i < 16; i++) begin tick_alt = (i % 8 == 7); step(); end
        tick_alt = 1'b0;
        chk("ch2_halt0", d2, 16'd0);
        wr(2'd1, 16'h0203);
        addr = 2'd0;
        for (int i = 0; i < 16; i++) begin tick_alt = (i % 8 == 7); step(); end
        tick_alt = 1'b0;
        chk("ch2_free1", d2, 16'd2);
        wr(2'd1, 16'h0207);
        addr = 2'd0;
        for (int i = 0; i < 16; i++) begin tick_alt = (i % 8 == 7); step(); end
        tick_alt = 1'b0;
        chk("ch2_halt3", d2, 16'd0);

        // toggle request with repeat: edges every 3 cycles when enabled
        wr(2'd2, 16'd2);
        wr(2'd1, 16'h00D8);
        prev = irq0;
        trans = 0;
        repeat (12) begin
            step();
            if (irq0 != prev) trans++;
            prev = irq0;
        end
        chk("toggle_edges", 16'(trans), TOG_EN ? 16'd4 : 16'd7);

        // randomized traffic on all three channels
        for (int i = 0; i < 1500; i++) begin
            wen = ($urandom_range(0, 7) == 0);
            ren = ($urandom_range(0, 3) == 0);
            addr = 2'($urandom_range(0, 3));
            ben = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: data_i = 16'($urandom);
                1: data_i = 16'hFFFF - 16'($urandom_range(0, 4));
                default: data_i = 16'($urandom_range(0, 12));
            endcase
            tick_alt = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) blank = ~blank;
            step();
        end

        // mid-run asynchronous reset between clock edges
        wen = 1'b0; ren = 1'b0; tick_alt = 1'b0; blank = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        reset_checks("midrst");
        @(negedge sys_clk);
        rst_n = 1'b1;
        addr = 2'd0;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
